// File: rtl/gray_code_converter_if.sv
// ----------------------------------------------------------------------------
// gray_code_converter_if
// Bundles the data/valid signals of one gray_code_converter instance.
//   in         : value to convert (binary or Gray depending on the converter mode)
//   in_valid   : qualifies in for the registered path
//   out        : combinational conversion of in
//   out_q      : registered conversion result
//   out_valid  : high when out_q was loaded on the previous edge
//   step_error : Gray-step violation flag (constant 0 unless step check is built)
// Modports: master drives in/in_valid, slave (the converter) drives the results.
// ----------------------------------------------------------------------------
interface gray_code_converter_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             out_valid;
    logic             step_error;

    modport master (
        output in,
        output in_valid,
        input  out,
        input  out_q,
        input  out_valid,
        input  step_error
    );

    modport slave (
        input  in,
        input  in_valid,
        output out,
        output out_q,
        output out_valid,
        output step_error
    );
endinterface

// File: rtl/gray_code_converter.sv
// ----------------------------------------------------------------------------
// gray_code_converter
// Parameterised binary <-> reflected Gray converter with a combinational result
// and a one-cycle registered copy.
//   WIDTH  : bit width of input and outputs (>= 1)
//   INVERT : 0 = binary -> Gray encode, 1 = Gray -> binary decode
// Ports:
//   clk    : rising-edge clock for the registered path
//   reset  : synchronous, active-high reset
//   bus    : gray_code_converter_if.slave (in, in_valid, out, out_q,
//            out_valid, step_error)
// Optional feature, enabled by defining GRAY_CODE_STEP_CHECK_EN:
//   remembers the Gray-domain value of the last accepted sample and raises
//   step_error for one cycle when the next accepted Gray value does not differ
//   from it in exactly one bit. Without the macro step_error is tied to 0.
// ----------------------------------------------------------------------------
module gray_code_converter #(
    parameter int WIDTH  = 16,
    parameter int INVERT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    gray_code_converter_if.slave bus
);

    logic [WIDTH-1:0] conv;
    logic [WIDTH-1:0] out_q_reg;
    logic             out_valid_reg;

    // ------------------------------------------------------------------
    // Combinational conversion
    // ------------------------------------------------------------------
    generate
        if (INVERT == 0) begin : g_encode
            assign conv = bus.in ^ (bus.in >> 1);
        end else begin : g_decode
            // Each binary bit is the parity of all Gray bits at or above it.
            // Written as a reduction per bit rather than a chained ripple so
            // the vector never feeds back on itself.
            for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
                assign conv[gi] = ^bus.in[WIDTH-1:gi];
            end
        end
    endgenerate

    assign bus.out = conv;

    // ------------------------------------------------------------------
    // Registered copy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                out_q_reg <= conv;
            end
        end
    end

    assign bus.out_q     = out_q_reg;
    assign bus.out_valid = out_valid_reg;

    // ------------------------------------------------------------------
    // Optional Gray step check
    // ------------------------------------------------------------------
`ifdef GRAY_CODE_STEP_CHECK_EN
    logic [WIDTH-1:0] gray_val;
    logic [WIDTH-1:0] gray_diff;
    logic             diff_one_hot;
    logic [WIDTH-1:0] hist_reg;
    logic             have_hist_reg;
    logic             step_error_reg;

    // The Gray-domain value is the output when encoding, the input when decoding.
    generate
        if (INVERT == 0) begin : g_gray_enc
            assign gray_val = conv;
        end else begin : g_gray_dec
            assign gray_val = bus.in;
        end
    endgenerate

    assign gray_diff    = gray_val ^ hist_reg;
    // Zero difference is not one-hot, so a repeated value is a violation.
    assign diff_one_hot = (gray_diff != '0) &&
                          ((gray_diff & (gray_diff - WIDTH'(1))) == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_reg       <= '0;
            have_hist_reg  <= 1'b0;
            step_error_reg <= 1'b0;
        end else if (bus.in_valid) begin
            hist_reg       <= gray_val;
            have_hist_reg  <= 1'b1;
            step_error_reg <= have_hist_reg && !diff_one_hot;
        end else begin
            step_error_reg <= 1'b0;
        end
    end

    assign bus.step_error = step_error_reg;
`else
    assign bus.step_error = 1'b0;
`endif

endmodule

// File: tb/tb_gray_code_converter.sv
// ----------------------------------------------------------------------------
// tb_gray_code_converter
// Checks gray_code_converter: an encoder chained into a decoder (exhaustive
// 16-bit sweep), spot values, WIDTH=1 in both modes, the registered path of
// the encoder, and a standalone decoder driven with directed and randomized
// samples against a behavioural model (including the optional step check when
// GRAY_CODE_STEP_CHECK_EN is defined).
// ----------------------------------------------------------------------------
module tb_gray_code_converter;

    logic clk;
    logic reset;

    int checks;
    int fails;

    gray_code_converter_if #(.WIDTH(16)) enc_if ();
    gray_code_converter_if #(.WIDTH(16)) dec_if ();
    gray_code_converter_if #(.WIDTH(16)) ds_if ();
    gray_code_converter_if #(.WIDTH(1))  w1e_if ();
    gray_code_converter_if #(.WIDTH(1))  w1d_if ();

    gray_code_converter #(.WIDTH(16), .INVERT(0)) u_enc (.clk(clk), .reset(reset), .bus(enc_if));
    gray_code_converter #(.WIDTH(16), .INVERT(1)) u_dec (.clk(clk), .reset(reset), .bus(dec_if));
    gray_code_converter #(.WIDTH(16), .INVERT(1)) u_ds  (.clk(clk), .reset(reset), .bus(ds_if));
    gray_code_converter #(.WIDTH(1),  .INVERT(0)) u_w1e (.clk(clk), .reset(reset), .bus(w1e_if));
    gray_code_converter #(.WIDTH(1),  .INVERT(1)) u_w1d (.clk(clk), .reset(reset), .bus(w1d_if));

    // Decoder is fed straight from the encoder output.
    assign dec_if.in = enc_if.out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state for the standalone decoder u_ds.
    logic [15:0] m_q;
    logic        m_v;
    logic        m_err;
    logic [15:0] m_hist;
    logic        m_have;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Gray -> binary from its definition: bit i is the parity of Gray bits >= i.
    function automatic logic [15:0] ref_decode(input logic [15:0] g);
        logic [15:0] r;
        logic [15:0] t;
        for (int i = 0; i < 16; i++) begin
            t    = g >> i;
            r[i] = ^t;
        end
        return r;
    endfunction

    // Binary -> Gray from its definition: g[i] = b[i] XOR b[i+1], MSB copied.
    function automatic logic [15:0] ref_encode(input logic [15:0] b);
        logic [15:0] r;
        for (int i = 0; i < 15; i++) r[i] = b[i] ^ b[i+1];
        r[15] = b[15];
        return r;
    endfunction

    // One clock step of the standalone decoder, checked against the model.
    task automatic dstep(input logic [15:0] v, input logic vld, input logic rst);
        ds_if.in       = v;
        ds_if.in_valid = vld;
        reset          = rst;
        tick();
        if (rst) begin
            m_q = '0; m_v = 1'b0; m_err = 1'b0; m_have = 1'b0; m_hist = '0;
        end else if (vld) begin
            m_q = ref_decode(v);
            m_v = 1'b1;
`ifdef GRAY_CODE_STEP_CHECK_EN
            m_err = m_have && ($countones(v ^ m_hist) != 1);
`else
            m_err = 1'b0;
`endif
            m_hist = v;
            m_have = 1'b1;
        end else begin
            m_v   = 1'b0;
            m_err = 1'b0;
        end
        $display("ds step in=%04h vld=%0d rst=%0d -> out_q=%04h out_valid=%0d step_error=%0d",
                 v, vld, rst, ds_if.out_q, ds_if.out_valid, ds_if.step_error);
        check("ds_out_q",      32'(ds_if.out_q),      32'(m_q));
        check("ds_out_valid",  32'(ds_if.out_valid),  32'(m_v));
        check("ds_step_error", 32'(ds_if.step_error), 32'(m_err));
    endtask

    initial begin
        logic [15:0] prev;
        logic [15:0] v;
        checks = 0;
        fails  = 0;
        reset  = 1'b1;
        enc_if.in = '0; enc_if.in_valid = 1'b0;
        dec_if.in_valid = 1'b0;
        ds_if.in = '0;  ds_if.in_valid = 1'b0;
        w1e_if.in = 1'b0; w1e_if.in_valid = 1'b0;
        w1d_if.in = 1'b0; w1d_if.in_valid = 1'b0;
        m_q = '0; m_v = 1'b0; m_err = 1'b0; m_hist = '0; m_have = 1'b0;

        // Reset state of the encoder registered path (2 cycles of reset).
        tick();
        tick();
        $display("reset: out_q=%04h out_valid=%0d step_error=%0d",
                 enc_if.out_q, enc_if.out_valid, enc_if.step_error);
        check("rst_out_q",      32'(enc_if.out_q),      32'h0);
        check("rst_out_valid",  32'(enc_if.out_valid),  32'h0);
        check("rst_step_error", 32'(enc_if.step_error), 32'h0);

        // out follows in even while reset is asserted.
        enc_if.in = 16'h0005;
        #1;
        check("comb_in_reset", 32'(enc_if.out), 32'h0007);
        reset = 1'b0;

        // Spot values, encode and decode.
        enc_if.in = 16'h0005; #1;
        $display("enc 0005 -> %04h", enc_if.out);
        check("enc_0005", 32'(enc_if.out), 32'h0007);
        enc_if.in = 16'h8000; #1;
        $display("enc 8000 -> %04h", enc_if.out);
        check("enc_8000", 32'(enc_if.out), 32'hC000);
        enc_if.in = 16'hFFFF; #1;
        $display("enc FFFF -> %04h", enc_if.out);
        check("enc_FFFF", 32'(enc_if.out), 32'h8000);
        ds_if.in = 16'h0007; #1;
        $display("dec 0007 -> %04h", ds_if.out);
        check("dec_0007", 32'(ds_if.out), 32'h0005);
        ds_if.in = 16'hC000; #1;
        $display("dec C000 -> %04h", ds_if.out);
        check("dec_C000", 32'(ds_if.out), 32'h8000);

        // WIDTH=1 is the identity in both modes.
        for (int b = 0; b < 2; b++) begin
            w1e_if.in = 1'(b);
            w1d_if.in = 1'(b);
            #1;
            $display("w1 in=%0d enc=%0d dec=%0d", b, w1e_if.out, w1d_if.out);
            check("w1_enc", 32'(w1e_if.out), 32'(b));
            check("w1_dec", 32'(w1d_if.out), 32'(b));
        end

        // Exhaustive sweep: adjacency of the encoder, round trip through decoder.
        prev = 16'h0000;
        for (int x = 1; x < 65536; x++) begin
            enc_if.in = 16'(x);
            #1;
            check("sweep_onehot",    32'($countones(enc_if.out ^ prev)), 32'd1);
            check("sweep_roundtrip", 32'(dec_if.out), 32'(x));
            prev = enc_if.out;
        end
        $display("sweep 1..65535 done, last gray=%04h", prev);
        // Wrap 65535 -> 0 differs only in the MSB.
        check("sweep_wrap", 32'(prev ^ ref_encode(16'h0000)), 32'h8000);

        // Random spot checks against the definitional encoder/decoder.
        for (int n = 0; n < 64; n++) begin
            v = 16'($urandom);
            enc_if.in = v;
            ds_if.in  = v;
            #1;
            $display("rand %04h enc=%04h dec=%04h", v, enc_if.out, ds_if.out);
            check("rand_enc", 32'(enc_if.out), 32'(ref_encode(v)));
            check("rand_dec", 32'(ds_if.out),  32'(ref_decode(v)));
        end

        // Encoder registered path.
        reset = 1'b1; enc_if.in_valid = 1'b0;
        tick(); tick();
        check("reg_rst_q", 32'(enc_if.out_q),     32'h0);
        check("reg_rst_v", 32'(enc_if.out_valid), 32'h0);
        reset = 1'b0; enc_if.in = 16'h0003; enc_if.in_valid = 1'b1;
        tick();
        $display("reg load 0003 -> out_q=%04h out_valid=%0d", enc_if.out_q, enc_if.out_valid);
        check("reg_load_q", 32'(enc_if.out_q),     32'h0002);
        check("reg_load_v", 32'(enc_if.out_valid), 32'h1);
        enc_if.in = 16'h1234; enc_if.in_valid = 1'b0;
        tick();
        $display("reg hold -> out_q=%04h out_valid=%0d", enc_if.out_q, enc_if.out_valid);
        check("reg_hold_q", 32'(enc_if.out_q),     32'h0002);
        check("reg_hold_v", 32'(enc_if.out_valid), 32'h0);
        reset = 1'b1; enc_if.in_valid = 1'b1;
        tick();
        $display("reg reset+valid -> out_q=%04h out_valid=%0d", enc_if.out_q, enc_if.out_valid);
        check("reg_rstwin_q", 32'(enc_if.out_q),     32'h0);
        check("reg_rstwin_v", 32'(enc_if.out_valid), 32'h0);
        enc_if.in_valid = 1'b0;

        // Standalone decoder: directed step-check sequence.
        dstep(16'h0000, 1'b0, 1'b1);
        dstep(16'h0000, 1'b0, 1'b1);
        dstep(16'h0000, 1'b1, 1'b0);
        dstep(16'h0001, 1'b1, 1'b0);
        dstep(16'h0003, 1'b1, 1'b0);
        dstep(16'h0000, 1'b1, 1'b0);   // two-bit change
`ifdef GRAY_CODE_STEP_CHECK_EN
        check("step_two_bit", 32'(ds_if.step_error), 32'h1);
`else
        check("step_two_bit", 32'(ds_if.step_error), 32'h0);
`endif
        dstep(16'h0000, 1'b1, 1'b0);   // zero change
        dstep(16'h0000, 1'b0, 1'b0);   // idle edge clears the flag
        dstep(16'h0000, 1'b1, 1'b1);   // reset wins, clears history
        dstep(16'hABCD, 1'b1, 1'b0);   // first after reset: never flagged
        check("step_after_rst", 32'(ds_if.step_error), 32'h0);

        // Randomized stream: mostly single-bit steps with occasional jumps.
        for (int n = 0; n < 300; n++) begin
            logic rst_r, vld_r;
            rst_r = ($urandom_range(0, 19) == 0);
            vld_r = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0)
                v = m_hist ^ (16'h0001 << $urandom_range(0, 15));
            else
                v = 16'($urandom);
            dstep(v, vld_r, rst_r);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
